// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU op encodings,
// arbiter FSM state encoding, bus widths and small helpers.
package alu_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int OPND_W  = 8;
    localparam int RES_W   = 16;
    localparam int OP_W    = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_XOR     = 3'b010,
        OP_ADD     = 3'b011,
        OP_SUB     = 3'b100,
        OP_MUL     = 3'b101,
        OP_DIV     = 3'b110,
        OP_ILLEGAL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return op == OP_ILLEGAL;
    endfunction

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return op == OP_DIV;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bus plus ALU-side signals of the arbiter; slave is the
// arbiter view, master is the view of the requesters and the ALU together.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*OPND_W-1:0] req_x;
    logic [NUM_REQ*OPND_W-1:0] req_y;
    logic [NUM_REQ*OPND_W-1:0] req_ahi;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [RES_W-1:0]          rsp_data;
    logic                      rsp_err;

    logic [OPND_W-1:0]         alu_x;
    logic [OPND_W-1:0]         alu_y;
    logic [OPND_W-1:0]         alu_a_divide;
    logic [OP_W-1:0]           alu_op;
    logic                      alu_begin;
    logic [RES_W-1:0]          alu_out;
    logic                      alu_end;

    modport slave (
        input  req_valid, req_op, req_x, req_y, req_ahi, rsp_ready, alu_out, alu_end,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               alu_x, alu_y, alu_a_divide, alu_op, alu_begin
    );

    modport master (
        output req_valid, req_op, req_x, req_y, req_ahi, rsp_ready, alu_out, alu_end,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               alu_x, alu_y, alu_a_divide, alu_op, alu_begin
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the
// requester that was not served last wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign grant[gi] = valid[gi] & (~valid[1-gi] | (last != 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one multi-cycle ALU: grant, issue, wait for
// completion or timeout, then hold the response until the winner takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         resetn,
    alu_arbiter_if.slave arb_if
);

    localparam int              CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_e         state_q;
    logic               gnt_q;
    logic               last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [RES_W-1:0]   rsp_data_q;
    logic               rsp_err_q;
    logic [OPND_W-1:0]  alu_x_q;
    logic [OPND_W-1:0]  alu_y_q;
    logic [OPND_W-1:0]  alu_adiv_q;
    logic [OP_W-1:0]    alu_op_q;
    logic               alu_begin_q;

    logic [OP_W-1:0]    lane_op  [NUM_REQ];
    logic [OPND_W-1:0]  lane_x   [NUM_REQ];
    logic [OPND_W-1:0]  lane_y   [NUM_REQ];
    logic [OPND_W-1:0]  lane_ahi [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_op[gi]  = arb_if.req_op[gi*OP_W +: OP_W];
            assign lane_x[gi]   = arb_if.req_x[gi*OPND_W +: OPND_W];
            assign lane_y[gi]   = arb_if.req_y[gi*OPND_W +: OPND_W];
            assign lane_ahi[gi] = arb_if.req_ahi[gi*OPND_W +: OPND_W];
        end
    endgenerate

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic               grant_idx;
    logic [OP_W-1:0]    sel_op;
    logic [OPND_W-1:0]  sel_x;
    logic [OPND_W-1:0]  sel_y;
    logic [OPND_W-1:0]  sel_ahi;
    logic               rsp_taken;

    rr_arb2 u_rr_arb2 (
        .valid (arb_if.req_valid),
        .last  (last_q),
        .grant (grant)
    );

    assign grant_any = |grant;
    assign grant_idx = grant[1];
    assign sel_op    = lane_op[grant_idx];
    assign sel_x     = lane_x[grant_idx];
    assign sel_y     = lane_y[grant_idx];
    assign sel_ahi   = lane_ahi[grant_idx];
    assign rsp_taken = arb_if.rsp_ready[gnt_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_adiv_q  <= '0;
            alu_op_q    <= '0;
            alu_begin_q <= 1'b0;
        end else begin
            alu_begin_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        gnt_q  <= grant_idx;
                        last_q <= grant_idx;
                        // Illegal ops answer immediately and never disturb the ALU pins.
                        if (op_is_illegal(sel_op)) begin
                            rsp_valid_q <= grant;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            alu_op_q    <= sel_op;
                            alu_x_q     <= sel_x;
                            alu_y_q     <= sel_y;
                            alu_adiv_q  <= op_is_div(sel_op) ? sel_ahi : '0;
                            alu_begin_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion in the same cycle the count expires still wins.
                    if (arb_if.alu_end) begin
                        rsp_valid_q <= idx_to_onehot(gnt_q);
                        rsp_data_q  <= arb_if.alu_out;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CNT_MAX) begin
                        rsp_valid_q <= idx_to_onehot(gnt_q);
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_taken) begin
                        rsp_valid_q <= '0;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Grant is visible in the IDLE cycle itself; reset masks it immediately.
    assign arb_if.req_ready    = (resetn && (state_q == ST_IDLE)) ? grant : '0;
    assign arb_if.rsp_valid    = rsp_valid_q;
    assign arb_if.rsp_data     = rsp_data_q;
    assign arb_if.rsp_err      = rsp_err_q;
    assign arb_if.alu_x        = alu_x_q;
    assign arb_if.alu_y        = alu_y_q;
    assign arb_if.alu_a_divide = alu_adiv_q;
    assign arb_if.alu_op       = alu_op_q;
    assign arb_if.alu_begin    = alu_begin_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// transactions against a transaction-level model and a behavioural ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    alu_arbiter_if arb_if ();

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .arb_if (arb_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] r_op  [2];
    logic [7:0] r_x   [2];
    logic [7:0] r_y   [2];
    logic [7:0] r_ahi [2];

    int         alu_lat;
    int         alu_cnt;
    bit         alu_active;
    bit         watch_ops;
    int         begin_cnt;
    logic [2:0] s_op;
    logic [7:0] s_x, s_y, s_adiv;
    int         m_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] ahi,
                                            input logic [7:0] x, input logic [7:0] y);
        logic [15:0] dvd;
        logic [15:0] q;
        logic [15:0] r;
        dvd = {ahi, x};
        q   = 16'h0;
        r   = 16'h0;
        case (op)
            3'd0: return {8'h00, x & y};
            3'd1: return {8'h00, x | y};
            3'd2: return {8'h00, x ^ y};
            3'd3: return 16'(x) + 16'(y);
            3'd4: return 16'(x) - 16'(y);
            3'd5: return 16'(x) * 16'(y);
            3'd6: begin
                if (y == 8'h00) return 16'hFFFF;
                q = dvd / 16'(y);
                r = dvd % 16'(y);
                return {r[7:0], q[7:0]};
            end
            default: return 16'h0000;
        endcase
    endfunction

    // One clock: advance, then play the ALU (latency alu_lat cycles after the
    // begin cycle, 0 = never answers) and watch operand stability in WAIT.
    task automatic tick();
        @(posedge clk);
        #1;
        arb_if.alu_end = 1'b0;
        if (arb_if.rsp_valid != 2'b00) watch_ops = 1'b0;
        if (arb_if.alu_begin) begin
            begin_cnt++;
            s_op   = arb_if.alu_op;
            s_x    = arb_if.alu_x;
            s_y    = arb_if.alu_y;
            s_adiv = arb_if.alu_a_divide;
            arb_if.alu_out = alu_ref(s_op, s_adiv, s_x, s_y);
            alu_active = 1'b1;
            watch_ops  = 1'b1;
            alu_cnt    = alu_lat;
        end else begin
            if (watch_ops)
                check_eq("alu_hold", 32'({arb_if.alu_op, arb_if.alu_a_divide, arb_if.alu_x, arb_if.alu_y}),
                         32'({s_op, s_adiv, s_x, s_y}));
            if (alu_active && alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    arb_if.alu_end = 1'b1;
                    alu_active     = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic drive_lanes();
        arb_if.req_op  = {r_op[1], r_op[0]};
        arb_if.req_x   = {r_x[1], r_x[0]};
        arb_if.req_y   = {r_y[1], r_y[0]};
        arb_if.req_ahi = {r_ahi[1], r_ahi[0]};
    endtask

    task automatic run_txn(input logic [1:0] vmask, input int lat, input int hold, input bit keep_other);
        int          g;
        int          cyc;
        int          exp_lat;
        int          b0;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [1:0]  gmask;
        drive_lanes();
        arb_if.req_valid = vmask;
        alu_lat = lat;
        #1;
        if (vmask == 2'b11) g = (m_last == 1) ? 0 : 1;
        else                g = vmask[1] ? 1 : 0;
        gmask = (g == 1) ? 2'b10 : 2'b01;
        check_eq("grant", 32'(arb_if.req_ready), 32'(gmask));
        m_last = g;
        if (r_op[g] == 3'b111) begin
            exp_err = 1'b1; exp_data = 16'h0; exp_lat = 1;
        end else if (lat != 0 && lat <= TO + 1) begin
            exp_err  = 1'b0;
            exp_data = alu_ref(r_op[g], (r_op[g] == 3'd6) ? r_ahi[g] : 8'h00, r_x[g], r_y[g]);
            exp_lat  = lat + 2;
        end else begin
            exp_err = 1'b1; exp_data = 16'h0; exp_lat = TO + 3;
        end
        b0 = begin_cnt;
        tick();
        arb_if.req_valid = keep_other ? (vmask & ~gmask) : 2'b00;
        cyc = 1;
        while (arb_if.rsp_valid == 2'b00 && cyc < 60) begin
            check_eq("ready_busy", 32'(arb_if.req_ready), 32'h0);
            tick();
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("rsp_valid", 32'(arb_if.rsp_valid), 32'(gmask));
        check_eq("rsp_data", 32'(arb_if.rsp_data), 32'(exp_data));
        check_eq("rsp_err", 32'(arb_if.rsp_err), 32'(exp_err));
        check_eq("begins", 32'(begin_cnt - b0), (r_op[g] == 3'b111) ? 32'd0 : 32'd1);
        if (r_op[g] != 3'b111)
            check_eq("alu_ops", 32'({s_op, s_adiv, s_x, s_y}),
                     32'({r_op[g], (r_op[g] == 3'd6) ? r_ahi[g] : 8'h00, r_x[g], r_y[g]}));
        for (int h = 0; h < hold; h++) begin
            arb_if.rsp_ready = ~gmask;
            tick();
            check_eq("rsp_hold", 32'({arb_if.rsp_valid, arb_if.rsp_err, arb_if.rsp_data}),
                     32'({gmask, exp_err, exp_data}));
        end
        arb_if.rsp_ready = gmask;
        tick();
        arb_if.rsp_ready = 2'b00;
        check_eq("rsp_done", 32'(arb_if.rsp_valid), 32'h0);
        $display("txn req=%0d op=%0d lat=%0d -> data=0x%04h err=%0d cycles=%0d",
                 g, r_op[g], lat, exp_data, exp_err, cyc);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, 32'({arb_if.req_ready, arb_if.rsp_valid, arb_if.rsp_err, arb_if.alu_begin}), 32'h0);
        check_eq({tag, "_data"}, 32'(arb_if.rsp_data), 32'h0);
        check_eq({tag, "_alu"}, 32'({arb_if.alu_op, arb_if.alu_a_divide, arb_if.alu_x, arb_if.alu_y}), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] vm;
        logic [1:0] pend;
        bit         keep;

        resetn = 1'b0;
        arb_if.req_valid = 2'b00;
        arb_if.req_op    = '0;
        arb_if.req_x     = '0;
        arb_if.req_y     = '0;
        arb_if.req_ahi   = '0;
        arb_if.rsp_ready = 2'b00;
        arb_if.alu_out   = '0;
        arb_if.alu_end   = 1'b0;
        alu_lat = 1; alu_cnt = 0; alu_active = 1'b0; watch_ops = 1'b0;
        begin_cnt = 0; m_last = 1;
        s_op = '0; s_x = '0; s_y = '0; s_adiv = '0;
        for (int i = 0; i < 2; i++) begin
            r_op[i] = 3'd0; r_x[i] = 8'h0; r_y[i] = 8'h0; r_ahi[i] = 8'h0;
        end

        #12;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Contention right after reset: requester 0 first, requester 1 next.
        r_op[0] = OP_MUL; r_x[0] = 8'd12;  r_y[0] = 8'd11;
        r_op[1] = OP_AND; r_x[1] = 8'hAA;  r_y[1] = 8'h0F;
        run_txn(2'b11, 2, 0, 1'b1);
        run_txn(2'b10, 1, 0, 1'b0);

        r_op[0] = OP_ADD; r_x[0] = 8'd17; r_y[0] = 8'd5;
        run_txn(2'b01, 3, 0, 1'b0);

        r_op[1] = OP_DIV; r_ahi[1] = 8'h16; r_x[1] = 8'h8B; r_y[1] = 8'h87;
        run_txn(2'b10, 4, 1, 1'b0);

        r_op[0] = OP_ILLEGAL; r_x[0] = 8'h55; r_y[0] = 8'h66;
        run_txn(2'b01, 3, 1, 1'b0);

        // Timeout with a stalled consumer, then the count boundary either side.
        r_op[0] = OP_SUB; r_x[0] = 8'd3; r_y[0] = 8'd9;
        run_txn(2'b01, 0, 5, 1'b0);
        run_txn(2'b01, TO + 1, 0, 1'b0);
        run_txn(2'b01, TO + 2, 0, 1'b0);

        pend = 2'b00;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    r_op[i]  = 3'($urandom_range(0, 7));
                    r_x[i]   = 8'($urandom_range(0, 255));
                    r_y[i]   = 8'($urandom_range(0, 255));
                    r_ahi[i] = 8'($urandom_range(0, 255));
                end
            end
            vm   = pend | 2'($urandom_range(1, 3));
            keep = 1'($urandom_range(0, 1));
            run_txn(vm, $urandom_range(0, 7), $urandom_range(0, 3), keep);
            pend = keep ? (vm & ((m_last == 1) ? 2'b01 : 2'b10)) : 2'b00;
        end
        arb_if.req_valid = 2'b00;
        tick();

        // Reset while waiting on the ALU: op abandoned, requester 0 wins next.
        r_op[0] = OP_ADD; r_x[0] = 8'd1; r_y[0] = 8'd2;
        drive_lanes();
        alu_lat = 0;
        arb_if.req_valid = 2'b01;
        tick();
        arb_if.req_valid = 2'b00;
        tick();
        tick();
        tick();
        arb_if.req_valid = 2'b11;
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        arb_if.req_valid = 2'b00;
        alu_active = 1'b0;
        watch_ops  = 1'b0;
        m_last     = 1;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("no_stale", 32'(arb_if.rsp_valid), 32'h0);
        end
        r_op[0] = OP_XOR; r_x[0] = 8'hF0; r_y[0] = 8'h3C;
        r_op[1] = OP_OR;  r_x[1] = 8'h01; r_y[1] = 8'h80;
        run_txn(2'b11, 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
